gpio_bus_arbiter: RTL and testbench
===================================

// Module: gpio_bus_arbiter
// PURPOSE
//  Two-requester round-robin arbiter sharing the memory-mapped GPIO register port (WE/A/WD/RD) between
//  requester 0 (CPU memory stage) and requester 1 (debug/DMA master). Serialises one transaction at a
//  time, drives the GPIO port for exactly one cycle and returns the GPIO's registered RD with a pulse.
// PARAMETERS
//  ADDR_W     32  address width of requesters and peripheral port
//  DATA_W     32  data width of WD/RD
//  RESET_PRIO 0   requester that wins the first tie after reset (0 or 1)
// PORTS
//  CLK        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  req0/req1  in   1       request; held with command stable until matching gnt
//  we0/we1    in   1       1 = write, 0 = read
//  addr0/1    in   ADDR_W  target address
//  wdata0/1   in   DATA_W  write data
//  gnt0/gnt1  out  1       one-cycle pulse: command captured
//  rvalid0/1  out  1       one-cycle pulse: rdata valid for that requester
//  rdata      out  DATA_W  response data (shared, qualified by rvalid0/1)
//  per_WE     out  1       to GPIO WE
//  per_A      out  ADDR_W  to GPIO A
//  per_WD     out  DATA_W  to GPIO WD
//  per_RD     in   DATA_W  from GPIO RD (registered, valid one cycle after A presented)
// BEHAVIOUR
//  Reset: state=IDLE, gnt*/rvalid*=0, rdata=0, per_WE=0, per_A=0, per_WD=0, last-grant ptr = !RESET_PRIO.
//  FSM (registered): IDLE -> ISSUE -> RESP -> IDLE.
//   IDLE : if any req, pick winner, latch we/addr/wdata and winner id at the edge; next ISSUE.
//   ISSUE: gnt<winner>=1; per_WE=latched we; per_A/per_WD=latched addr/wdata. Next RESP.
//   RESP : per_RD valid; rdata<=per_RD at the edge; rvalid<winner> pulses the following cycle. Next IDLE.
//  Outside ISSUE: per_WE=0, per_A=0, per_WD=0 (no spurious GPIO writes/reads).
//  Latency: req seen in cycle T -> gnt in T+1 -> rvalid+rdata in T+3. Throughput 1 txn per 3 cycles;
//   IDLE in the rvalid cycle may accept the next request (back-to-back, no bubble beyond that).
//  Writes also produce rvalid; rdata = GPIO RD sampled at the write edge (= pin value before the write).
//  Arbitration: single req -> that requester. Both -> requester != last granted (round-robin);
//   ptr updates only on a grant. A requester never waits more than one other transaction.
//  Requests arriving during ISSUE/RESP are held off (no gnt) and considered in the next IDLE.
//  rdata holds its value until the next RESP; rvalid0 and rvalid1 never both high; gnt likewise.
//  Deasserting req before gnt withdraws the request; after the capture edge it has no effect.
//  Reset mid-transaction: immediate return to reset values; in-flight txn dropped, no rvalid issued.
// STRUCTURE
//  Shared package/header gpio_arb_pkg: state encoding localparams (ST_IDLE=2'd0, ST_ISSUE=2'd1,
//   ST_RESP=2'd2), requester-id width, and the GPIO base address 32'h80000000 for benches.
//  One sub-module rr_arbiter2: combinational pick from {req1,req0} + registered last-grant ptr,
//   advance strobe input; top holds FSM, command latch and response register.
// TESTING
//  1 req0 write addr 0x80000000 wdata 0x1 -> gnt0 at T+1, per_WE=1 only that cycle, rvalid0 at T+3,
//    rdata=0 (pin was 0); GPIO pin=1 afterwards.
//  2 req1 read 0x80000000 after test 1 -> gnt1, per_WE=0, rvalid1 at T+3 with rdata=0x00000001.
//  3 req0 and req1 asserted together and held, after reset (RESET_PRIO=0) -> grant order 0,1,0,1;
//    each gnt 3 cycles apart; no simultaneous gnt/rvalid.
//  4 req1 held while req0 txn in ISSUE -> no gnt1 until IDLE; then gnt1 exactly 3 cycles after gnt0.
//  5 Assert reset during RESP of a req0 read -> all outputs 0 next cycle, no rvalid0, pin unchanged,
//    subsequent req1 read completes normally.
//  6 Read of 0x80000004 -> rvalid with rdata=0x0; per_A returns to 0 outside ISSUE.

Source files
------------

// File: rtl/gpio_arb_pkg.sv
// Shared definitions for the GPIO bus arbiter.
//   - FSM state encoding (IDLE/ISSUE/RESP) as localparams plus an enum type.
//   - Requester-id width (two requesters -> 1 bit).
//   - GPIO base address, used by benches to address the pin register.
package gpio_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam int ID_W = 1;

  localparam logic [31:0] GPIO_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_RESP  = ST_RESP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker.
//   clk, rst     : clock, asynchronous active-high reset
//   req_i[1:0]   : {req1, req0}
//   advance_i    : a grant is being taken this cycle; record the winner
//   any_o        : at least one request present
//   grant_id_o   : winning requester id (combinational)
// The pointer remembers the last granted requester; on a tie the other
// requester wins. After reset the pointer holds !RESET_PRIO so that
// RESET_PRIO wins the first tie.
module rr_arbiter2
  import gpio_arb_pkg::*;
#(
  parameter int RESET_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_i,
  input  logic            advance_i,
  output logic            any_o,
  output logic [ID_W-1:0] grant_id_o
);

  localparam logic PTR_RST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

  logic ptr_q;

  always_comb begin
    any_o      = |req_i;
    grant_id_o = req_i[1];
    if (req_i == 2'b11) begin
      grant_id_o = ~ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PTR_RST;
    end else if (advance_i) begin
      ptr_q <= grant_id_o;
    end
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Shares the GPIO register port between two requesters, one transaction
// at a time: IDLE (pick + latch command) -> ISSUE (drive GPIO one cycle,
// pulse gnt) -> RESP (capture registered RD) -> IDLE (rvalid pulse).
// Ports:
//   CLK, reset             : clock, asynchronous active-high reset
//   req*/we*/addr*/wdata*  : requester commands, held until gnt*
//   gnt0/gnt1              : one-cycle pulse, command captured
//   rvalid0/rvalid1        : one-cycle pulse, rdata valid for that requester
//   rdata                  : shared response data, held until next RESP
//   per_WE/per_A/per_WD    : GPIO port, non-zero only during ISSUE
//   per_RD                 : GPIO read data, valid the cycle after per_A
//   dbg_state              : current FSM state
// Handshake: a requester raises req with a stable command and keeps it
// until it sees gnt; dropping req before gnt withdraws it. Every granted
// transaction (read or write) returns exactly one rvalid two cycles after
// its gnt, unless reset intervenes.
module gpio_bus_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RESET_PRIO = 0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              per_WE,
  output logic [ADDR_W-1:0] per_A,
  output logic [DATA_W-1:0] per_WD,
  input  logic [DATA_W-1:0] per_RD,
  output logic [1:0]        dbg_state
);

  arb_state_e        state_q, state_d;
  logic              capture;
  logic              any_req;
  logic [ID_W-1:0]   win_id;

  logic [ID_W-1:0]   id_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid0_q, rvalid1_q;

  rr_arbiter2 #(.RESET_PRIO(RESET_PRIO)) u_rr (
    .clk        (CLK),
    .rst        (reset),
    .req_i      ({req1, req0}),
    .advance_i  (capture),
    .any_o      (any_req),
    .grant_id_o (win_id)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          capture = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // GPIO port is forced to zero outside ISSUE so the peripheral never
  // sees a stray write or address.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    per_WE = 1'b0;
    per_A  = '0;
    per_WD = '0;
    if (state_q == S_ISSUE) begin
      gnt0   = (id_q == 1'b0);
      gnt1   = (id_q == 1'b1);
      per_WE = we_q;
      per_A  = addr_q;
      per_WD = wdata_q;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        id_q    <= win_id;
        we_q    <= win_id ? we1    : we0;
        addr_q  <= win_id ? addr1  : addr0;
        wdata_q <= win_id ? wdata1 : wdata0;
      end
      // For writes per_RD still carries the pre-write pin value.
      if (state_q == S_RESP) begin
        rdata_q <= per_RD;
      end
      rvalid0_q <= (state_q == S_RESP) && (id_q == 1'b0);
      rvalid1_q <= (state_q == S_RESP) && (id_q == 1'b1);
    end
  end

  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
module tb_gpio_bus_arbiter;
  import gpio_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, per_we;
  logic [DW-1:0] rdata, per_wd;
  logic [AW-1:0] per_a;
  logic [DW-1:0] per_rd = '0;
  logic [1:0]    dbg_state;

  gpio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RESET_PRIO(0)) dut (
    .CLK(clk), .reset(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .per_WE(per_we), .per_A(per_a), .per_WD(per_wd),
    .per_RD(per_rd), .dbg_state(dbg_state)
  );

  // Simple GPIO: one pin register at GPIO_BASE, everything else reads 0.
  // RD is registered and reflects the value before a same-cycle write.
  logic [DW-1:0] pin = '0;
  always @(posedge clk) begin
    per_rd <= (per_a == GPIO_BASE) ? pin : '0;
    if (per_we && per_a == GPIO_BASE) pin <= per_wd;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW:0] exp_q[$];     // {id, rdata}
  logic        exp_gnt_q[$]; // expected grant order
  int  gnt_cyc[2];
  int  last_gnt = -100;
  bit  check_gap = 0;
  bit  mon_en = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("gnt_onehot", {63'd0, gnt0 & gnt1}, 64'd0);
      check("rvalid_onehot", {63'd0, rvalid0 & rvalid1}, 64'd0);
      if (!(gnt0 || gnt1)) begin
        check("port_idle", {31'd0, per_we, per_a}, 64'd0);
        check("port_idle_wd", {32'd0, per_wd}, 64'd0);
      end
      if (gnt0 || gnt1) begin
        if (exp_gnt_q.size() == 0) begin
          check("unexpected_gnt", {63'd0, gnt1}, 64'hdead);
        end else begin
          check("gnt_order", {63'd0, gnt1}, {63'd0, exp_gnt_q.pop_front()});
        end
        if (check_gap && last_gnt >= 0) check("gnt_gap", 64'(cyc - last_gnt), 64'd3);
        last_gnt = cyc;
        gnt_cyc[gnt1 ? 1 : 0] = cyc;
      end
      if (rvalid0 || rvalid1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", {31'd0, rvalid1, rdata}, 64'hdead);
        end else begin
          check("resp", {31'd0, rvalid1, rdata}, {31'd0, exp_q.pop_front()});
        end
        check("resp_latency", 64'(cyc - gnt_cyc[rvalid1 ? 1 : 0]), 64'd2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    if (id == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
    else         begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
  endtask

  task automatic drop_req(input int id);
    if (id == 0) req0 = 0; else req1 = 0;
  endtask

  // Waits (on negedges) for gnt of requester id; returns cycles waited.
  task automatic wait_gnt(input int id, input int max, output int waited);
    waited = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      waited++;
      if ((id == 0 && gnt0) || (id == 1 && gnt1)) return;
    end
    check("gnt_timeout", 64'(id), 64'hffff);
    waited = -1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Single uncontended transaction issued from IDLE: checks gnt latency.
  task automatic txn(input string name, input int id, input logic we,
                     input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [DW-1:0] exp_rd);
    int w;
    exp_gnt_q.push_back(id[0]);
    exp_q.push_back({id[0], exp_rd});
    set_req(id, we, a, wd);
    wait_gnt(id, 10, w);
    check({name, "_gnt_lat"}, 64'(w), 64'd1);
    check({name, "_we"}, {63'd0, per_we}, {63'd0, we});
    check({name, "_addr"}, {32'd0, per_a}, {32'd0, a});
    drop_req(id);
    idle_cycles(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    repeat (3) @(negedge clk);
    rst = 0;
    // reset state
    check("rst_outs", {58'd0, gnt0, gnt1, rvalid0, rvalid1, per_we, 1'b0}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    idle_cycles(1);

    // 1: req0 write 1 to pin; old pin value 0 returned
    txn("t1", 0, 1'b1, GPIO_BASE, 32'h1, 32'h0);
    check("t1_pin", {32'd0, pin}, 64'h1);

    // 2: req1 read pin -> 1
    txn("t2", 1, 1'b0, GPIO_BASE, 32'h0, 32'h1);
    check("t2_rdata_hold", {32'd0, rdata}, 64'h1);

    // 3: fresh reset, both held -> 0,1,0,1, 3 cycles apart
    rst = 1; @(negedge clk); rst = 0; last_gnt = -100;
    check_gap = 1;
    for (int k = 0; k < 4; k++) begin
      exp_gnt_q.push_back(k[0]);
      exp_q.push_back({k[0], 32'h0});
    end
    set_req(0, 1'b0, GPIO_BASE + 8, 32'h0);
    set_req(1, 1'b0, GPIO_BASE + 8, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_gnt(k % 2, 10, w);
      if (k == 0) check("t3_first_lat", 64'(w), 64'd1);
    end
    drop_req(0); drop_req(1);
    idle_cycles(3);
    check_gap = 0;

    // 4: req1 raised while req0 in ISSUE -> gnt1 3 cycles after gnt0
    exp_gnt_q.push_back(1'b0); exp_q.push_back({1'b0, 32'h1});
    exp_gnt_q.push_back(1'b1); exp_q.push_back({1'b1, 32'hA5});
    set_req(0, 1'b1, GPIO_BASE, 32'hA5);
    wait_gnt(0, 10, w);
    drop_req(0);
    set_req(1, 1'b0, GPIO_BASE, 32'h0);
    wait_gnt(1, 10, w);
    check("t4_gnt1_gap", 64'(w), 64'd3);
    drop_req(1);
    idle_cycles(3);

    // 5: reset during RESP of a req0 read; no rvalid for it
    exp_gnt_q.push_back(1'b0);
    set_req(0, 1'b0, GPIO_BASE, 32'h0);
    wait_gnt(0, 10, w);
    drop_req(0);
    @(negedge clk);
    check("t5_in_resp", {62'd0, dbg_state}, {62'd0, ST_RESP});
    rst = 1;
    @(negedge clk);
    check("t5_rst_outs", {58'd0, gnt0, gnt1, rvalid0, rvalid1, per_we, 1'b0}, 64'd0);
    check("t5_rst_rdata", {32'd0, rdata}, 64'd0);
    rst = 0;
    check("t5_pin", {32'd0, pin}, 64'hA5);
    idle_cycles(1);
    txn("t5b", 1, 1'b0, GPIO_BASE, 32'h0, 32'hA5);

    // 6: read of unmapped 0x80000004 -> 0
    txn("t6", 0, 1'b0, GPIO_BASE + 4, 32'h0, 32'h0);
    check("t6_pa_after", {32'd0, per_a}, 64'd0);

    idle_cycles(3);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("exp_gnt_q_empty", 64'(exp_gnt_q.size()), 64'd0);
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
